// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;
    localparam logic LINE_IDLE  = 1'b1;

    // Counter width that stays legal when a count range collapses to one value
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - producer-side bus of the buffered UART transmitter
interface uart_tx_buffered_if;
    import uart_pkg::*;

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 clear_ovf;
    logic                 tx_pin;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 fifo_full;
    logic                 tx_overflow;

    modport master (
        output tx_start, tx_data, clear_ovf,
        input  tx_pin, tx_busy, tx_done, fifo_full, tx_overflow
    );

    modport slave (
        input  tx_start, tx_data, clear_ovf,
        output tx_pin, tx_busy, tx_done, fifo_full, tx_overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the UART shift engine
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - 8N1 LSB-first UART transmitter with byte FIFO
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_buffered_if.slave   bus
);

    localparam int             CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int             IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam int             FCW      = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state, state_nx;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic                 tx_pin_q, tx_pin_nx;
    logic                 tx_done_q, tx_done_nx;
    logic                 tx_busy_q, tx_busy_nx;
    logic                 overflow_q;

    logic                 push_ok;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic [FCW-1:0]       fifo_count;
    logic [FCW-1:0]       count_nx;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Full is judged on the registered count, so a pop in the same cycle never rescues a push
    assign push_ok  = bus.tx_start && !fifo_full;
    assign count_nx = fifo_count + FCW'(push_ok) - FCW'(fifo_pop);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (bus.tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_nx   = fifo_data;
                    bit_cnt_nx = '0;
                    state_nx   = START;
                end
            end
            START: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_nx = '0;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end else begin
                    bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_nx = '0;
                    shift_nx   = shift >> 1;
                    if (bit_idx == IDX_LAST)
                        state_nx = STOP;
                    else
                        bit_idx_nx = bit_idx + 1'b1;
                end else begin
                    bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_nx = '0;
                    // Chain the next queued byte straight into its start bit
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_nx = fifo_data;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are computed from the next state and registered for a glitch-free line
        case (state_nx)
            START:   tx_pin_nx = 1'b0;
            DATA:    tx_pin_nx = shift_nx[0];
            default: tx_pin_nx = LINE_IDLE;
        endcase
        tx_done_nx = (state_nx == STOP) && (bit_cnt_nx == CNT_LAST);
        tx_busy_nx = (state_nx != IDLE) || (count_nx != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_pin_q  <= LINE_IDLE;
            tx_done_q <= 1'b0;
            tx_busy_q <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            bit_idx   <= bit_idx_nx;
            shift     <= shift_nx;
            tx_pin_q  <= tx_pin_nx;
            tx_done_q <= tx_done_nx;
            tx_busy_q <= tx_busy_nx;
        end
    end

    // A dropped push outranks a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow_q <= 1'b0;
        else if (bus.tx_start && fifo_full)
            overflow_q <= 1'b1;
        else if (bus.clear_ovf)
            overflow_q <= 1'b0;
    end

    assign bus.tx_pin      = tx_pin_q;
    assign bus.tx_done     = tx_done_q;
    assign bus.tx_busy     = tx_busy_q;
    assign bus.fifo_full   = fifo_full;
    assign bus.tx_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_buffered_if bus();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending bytes plus a countdown of cycles left in the frame on the line
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         m_r   = 0;
    logic [7:0] m_b   = '0;
    logic       m_ovf = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        bit was_full;
        if (!reset) begin
            m_q.delete();
            m_r   = 0;
            m_ovf = 1'b0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (m_r <= 1 && m_q.size() > 0) begin
                m_b = m_q.pop_front();
                m_sent.push_back(m_b);
                m_r = FRAME;
            end else if (m_r > 0) begin
                m_r--;
            end
            if (bus.tx_start && !was_full)
                m_q.push_back(bus.tx_data);
            if (bus.tx_start && was_full)
                m_ovf = 1'b1;
            else if (bus.clear_ovf)
                m_ovf = 1'b0;
        end
    end

    function automatic logic model_pin();
        int k;
        if (m_r == 0)
            return 1'b1;
        k = (FRAME - m_r) / CPB;
        if (k == 0)
            return 1'b0;
        if (k == 9)
            return 1'b1;
        return m_b[k-1];
    endfunction

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("model_pin",  bus.tx_pin,      model_pin());
            check("model_done", bus.tx_done,     m_r == 1);
            check("model_busy", bus.tx_busy,     (m_r > 0) || (m_q.size() > 0));
            check("model_full", bus.fifo_full,   m_q.size() == DEPTH);
            check("model_ovf",  bus.tx_overflow, m_ovf);
        end
    end

    // Independent serial decoder: mid-bit sampling of tx_pin
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = '0;
    int         rx_phase = -1;
    always @(negedge clk) begin : decoder
        int k;
        if (!reset) begin
            rx_phase = -1;
        end else if (rx_phase < 0) begin
            if (bus.tx_pin === 1'b0)
                rx_phase = 0;
        end else begin
            rx_phase++;
            if (rx_phase % CPB == CPB / 2) begin
                k = rx_phase / CPB;
                if (k >= 1 && k <= 8)
                    rx_sh[k-1] = bus.tx_pin;
                else if (k == 9) begin
                    check("stop_bit", bus.tx_pin, 1);
                    rx_q.push_back(rx_sh);
                end
            end
            if (rx_phase == FRAME - 1)
                rx_phase = -1;
        end
    end

    int cyc = 0;
    int done_cyc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) if (reset && bus.tx_done) done_cyc.push_back(cyc);

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        cycle();
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.tx_busy && n < budget) begin
            cycle();
            n++;
        end
        check("idle_timeout", n < budget, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] d[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h55, 10'b1_01010101_0};

        bus.tx_start  = 1'b0;
        bus.tx_data   = '0;
        bus.clear_ovf = 1'b0;
        repeat (3) cycle();
        check("rst_pin",  bus.tx_pin,      1);
        check("rst_busy", bus.tx_busy,     0);
        check("rst_done", bus.tx_done,     0);
        check("rst_full", bus.fifo_full,   0);
        check("rst_ovf",  bus.tx_overflow, 0);
        reset = 1'b1;
        cycle();
        chk_en = 1'b1;

        // Single frames against hand-written waveforms; tx_data is scrambled after the push edge
        foreach (vecs[i]) begin
            wait_idle(200);
            bus.tx_start = 1'b1;
            bus.tx_data  = vecs[i].data;
            cycle();
            bus.tx_start = 1'b0;
            bus.tx_data  = 8'($urandom);
            @(posedge clk);
            for (int j = 0; j < FRAME; j++) begin
                @(negedge clk);
                check("frame_bit", bus.tx_pin, vecs[i].frame[j / CPB]);
                check("done_at", bus.tx_done, j == FRAME - 1);
            end
            cycle();
            check("busy_after_frame", bus.tx_busy, 0);
        end

        // Three back-to-back pushes: contiguous frames
        rx_q.delete();
        done_cyc.delete();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_idle(400);
        check("b2b_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_gap1", done_cyc[1] - done_cyc[0], FRAME);
            check("b2b_gap2", done_cyc[2] - done_cyc[1], FRAME);
            check("b2b_busy_drop", cyc - done_cyc[2], 1);
        end
        check("b2b_rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("b2b_rx0", rx_q[0], 8'h00);
            check("b2b_rx1", rx_q[1], 8'hFF);
            check("b2b_rx2", rx_q[2], 8'h3C);
        end

        // Six pushes into a four-deep FIFO: exactly the sixth is dropped
        rx_q.delete();
        foreach (d[i]) d[i] = 8'($urandom);
        foreach (d[i]) push(d[i]);
        check("ovf_full", bus.fifo_full, 1);
        check("ovf_set", bus.tx_overflow, 1);
        repeat (20) cycle();
        check("ovf_sticky", bus.tx_overflow, 1);
        bus.clear_ovf = 1'b1;
        cycle();
        bus.clear_ovf = 1'b0;
        check("ovf_cleared", bus.tx_overflow, 0);

        // Push while full on the pop cycle at the end of STOP
        begin
            int n = 0;
            while (!bus.tx_done && n < 100) begin
                cycle();
                n++;
            end
            check("done_timeout", n < 100, 1);
        end
        check("full_before_pop", bus.fifo_full, 1);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hEE;
        cycle();
        bus.tx_start = 1'b0;
        check("pop_push_ovf", bus.tx_overflow, 1);
        check("pop_push_full", bus.fifo_full, 0);

        // Clear together with an accepted push, then with a dropped push
        bus.clear_ovf = 1'b1;
        push(8'h11);
        check("clr_push_ovf", bus.tx_overflow, 0);
        check("clr_push_full", bus.fifo_full, 1);
        push(8'h22);
        bus.clear_ovf = 1'b0;
        check("clr_vs_set_ovf", bus.tx_overflow, 1);
        wait_idle(600);
        check("ovf_rx_count", rx_q.size(), 6);
        if (rx_q.size() == 6) begin
            for (int i = 0; i < 5; i++)
                check("ovf_rx_byte", rx_q[i], d[i]);
            check("ovf_rx_last", rx_q[5], 8'h11);
        end
        bus.clear_ovf = 1'b1;
        cycle();
        bus.clear_ovf = 1'b0;

        // Reset in the middle of a DATA bit with two bytes queued
        rx_q.delete();
        push(8'h55);
        push(8'h0F);
        push(8'hF0);
        repeat (10) cycle();
        #3;
        reset = 1'b0;
        #1;
        check("arst_pin",  bus.tx_pin,    1);
        check("arst_busy", bus.tx_busy,   0);
        check("arst_full", bus.fifo_full, 0);
        cycle();
        cycle();
        reset = 1'b1;
        begin
            int low_seen = 0;
            for (int i = 0; i < 100; i++) begin
                cycle();
                if (bus.tx_pin !== 1'b1)
                    low_seen++;
            end
            check("arst_line_idle", low_seen, 0);
        end
        check("arst_busy_after", bus.tx_busy, 0);
        check("arst_no_rx", rx_q.size(), 0);

        // Random traffic against the model
        rx_q.delete();
        m_sent.delete();
        for (int i = 0; i < 3000; i++) begin
            bus.tx_start  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 4 : 20));
            bus.tx_data   = 8'($urandom);
            bus.clear_ovf = ($urandom_range(0, 99) < 5);
            cycle();
        end
        bus.tx_start  = 1'b0;
        bus.clear_ovf = 1'b0;
        wait_idle(1000);
        repeat (2) cycle();
        check("rand_rx_count", rx_q.size(), m_sent.size());
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
            check("rand_rx_byte", rx_q[i], m_sent[i]);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered UART transmitter: 8N1 framing, LSB first, with a small byte FIFO in front of the shift engine.
- Lets a producer (CPU/ALU result path) queue several bytes back-to-back without polling busy.
- Sits in the UART top beside the receive path, clocked from the PLL-derived UART clock.
- Emits a per-byte done pulse and a sticky overflow flag.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit (≥1)
FIFO_DEPTH, 4, byte entries in the TX FIFO (power of 2, ≥2)

Ports:
clk  input  1  UART clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
tx_start  input  1  push strobe; tx_data written when high and FIFO not full
tx_data  input  8  byte to queue
clear_ovf  input  1  clears tx_overflow
tx_pin  output  1  serial line, idle high
tx_busy  output  1  high while FSM not IDLE or FIFO not empty
tx_done  output  1  one-cycle pulse on last cycle of each stop bit
fifo_full  output  1  FIFO count == FIFO_DEPTH
tx_overflow  output  1  sticky: push attempted while full

Behaviour:
Reset (reset low, async) forces:
- FSM to IDLE, FIFO count/pointers to 0.
- tx_pin=1, tx_busy=0, tx_done=0, fifo_full=0, tx_overflow=0.
- Reset mid-frame aborts the frame: tx_pin returns high immediately and queued bytes are discarded.

FIFO:
- Push when tx_start & !fifo_full.
- Push while full: byte dropped, tx_overflow set the next edge.
- Simultaneous push and pop: both happen; count unchanged.
- Full status uses the registered count before the pop, so a push while full is dropped even if a pop occurs the same cycle.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, STOP.
- Bit counter 0..CLKS_PER_BIT-1; bit index 0..7.
- IDLE: tx_pin=1. If FIFO non-empty, pop into the shift register and go to START.
- START: tx_pin=0 for CLKS_PER_BIT cycles, then DATA with index 0.
- DATA: tx_pin=shift[0] for CLKS_PER_BIT cycles, then shift right. After index 7 go to STOP.
- STOP: tx_pin=1 for CLKS_PER_BIT cycles. On the last cycle, tx_done=1. If the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.

Timing:
- Latency: tx_start sampled at edge E0 with FIFO empty and FSM IDLE → tx_pin low after edge E0+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- The shift register is loaded only at pop, so tx_data changes after the push edge do not affect the frame.

Other outputs:
- tx_overflow: set on a dropped push; cleared by clear_ovf. If both occur in the same cycle, set wins.
- tx_pin, tx_done and tx_busy are registered outputs (glitch-free line).

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP)
  - DATA_BITS=8
  - FRAME_BITS=10
  - line idle level constant
- Natural sub-module: uart_tx_fifo. Synchronous FIFO with push/pop/data/count/full/empty, same clk/reset.
- The FSM and shift register stay in the top of uart_tx_buffered.

Test Plan:
1. CLKS_PER_BIT=4, push 0xA5 from idle → tx_pin low one clock after the push edge. Bits 1,0,1,0,0,1,0,1 each held 4 cycles, then high 4 cycles. tx_done pulses once at cycle 40 of the frame.
2. Push 0x00, 0xFF, 0x3C on three consecutive cycles → three contiguous 40-cycle frames with no idle gap. Three tx_done pulses 40 cycles apart. tx_busy deasserts the cycle after the last STOP.
3. FIFO_DEPTH=4: push 6 bytes back-to-back from idle → first byte popped at E1. fifo_full asserts, and exactly one byte is dropped. tx_overflow=1 until clear_ovf, and serial output carries 5 correct bytes.
4. Push while full in the same cycle a pop occurs (end of STOP) → push dropped, tx_overflow set, count decremented.
5. Assert reset low mid-DATA of 0x55 with 2 bytes queued → tx_pin=1, tx_busy=0, fifo_full=0 asynchronously. After release, the line stays idle with no further frames.
6. clear_ovf and an overflowing push in the same cycle → tx_overflow remains 1.
